// File: rtl/block_stream_emitter_pkg.sv
// Shared definitions for the block stream emitter.
// Holds the command opcodes, the ASCII codes used by the keyword words,
// the FSM state encoding, the word selector and the word lengths.
package block_stream_emitter_pkg;

  // Command opcodes
  localparam logic [1:0] OP_BEGIN = 2'b00;
  localparam logic [1:0] OP_END   = 2'b01;
  localparam logic [1:0] OP_RAW   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  // ASCII codes (lower case letters of "begin" / "end")
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;

  // Clearing this bit turns an ASCII lower-case letter into upper case.
  localparam logic [7:0] CASE_BIT = 8'h20;

  // Word lengths including the trailing space
  localparam logic [2:0] LEN_BEGIN = 3'd6;
  localparam logic [2:0] LEN_END   = 3'd4;
  localparam logic [2:0] LEN_RAW   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WORD_BEGIN = 2'd0,
    WORD_END   = 2'd1,
    WORD_RAW   = 2'd2
  } word_e;

  function automatic logic [2:0] word_len(input word_e w);
    case (w)
      WORD_BEGIN: return LEN_BEGIN;
      WORD_END:   return LEN_END;
      default:    return LEN_RAW;
    endcase
  endfunction

endpackage

// File: rtl/block_stream_emitter_word_rom.sv
// block_word_rom: combinational character generator for the emitter.
// Ports:
//   word_i     - which word is being emitted (BEGIN, END, RAW)
//   idx_i      - character index inside the word
//   raw_char_i - byte returned for a RAW word
//   char_o     - character for (word, index), with CASE_MASK applied
module block_word_rom
  import block_stream_emitter_pkg::*;
#(
  parameter logic [4:0] CASE_MASK = 5'b00000
) (
  input  word_e       word_i,
  input  logic [2:0]  idx_i,
  input  logic [7:0]  raw_char_i,
  output logic [7:0]  char_o
);

  logic [7:0] base_char;
  logic       is_letter;
  logic [7:0] mask_ext;

  // Widened so any index value selects a defined bit.
  assign mask_ext = {3'b000, CASE_MASK};

  always_comb begin
    base_char = CH_SPACE;
    is_letter = 1'b0;
    case (word_i)
      WORD_BEGIN: begin
        case (idx_i)
          3'd0:    begin base_char = CH_B; is_letter = 1'b1; end
          3'd1:    begin base_char = CH_E; is_letter = 1'b1; end
          3'd2:    begin base_char = CH_G; is_letter = 1'b1; end
          3'd3:    begin base_char = CH_I; is_letter = 1'b1; end
          3'd4:    begin base_char = CH_N; is_letter = 1'b1; end
          default: base_char = CH_SPACE;
        endcase
      end
      WORD_END: begin
        case (idx_i)
          3'd0:    begin base_char = CH_E; is_letter = 1'b1; end
          3'd1:    begin base_char = CH_N; is_letter = 1'b1; end
          3'd2:    begin base_char = CH_D; is_letter = 1'b1; end
          default: base_char = CH_SPACE;
        endcase
      end
      default: base_char = raw_char_i;
    endcase
  end

  // Raw bytes pass untouched; only keyword letters are case-folded.
  assign char_o = (is_letter && mask_ext[idx_i]) ? (base_char & ~CASE_BIT) : base_char;

endmodule

// File: rtl/block_stream_emitter.sv
// block_stream_emitter: turns BEGIN/END/RAW/FLUSH commands into a
// byte-per-cycle ASCII stream and tracks block nesting depth.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low reset
//   cmd_valid  - command present
//   cmd        - opcode (00 BEGIN, 01 END, 10 RAW, 11 FLUSH)
//   raw_char   - byte emitted for RAW, sampled at acceptance
//   cmd_ready  - a command can be accepted this cycle
//   out        - character stream (registered)
//   out_valid  - out carries an emitted character
//   depth      - current open-block count
//   balanced   - depth==0 and no sticky error
//   err        - sticky: END at depth 0 or BEGIN at max depth
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight, out idles at space, ready for a command
// ST_EMIT  | emitting one BEGIN/END/RAW word, idx_q = next char to load
// ST_FLUSH | emitting END words until depth reaches zero
//
// idx_q points at the character that the next edge loads into out.
// cmd_ready rises in the cycle before the last character appears on out,
// so a command accepted at that edge has its first character on out
// right after the last one of the current word: words run gap-free.
module block_stream_emitter
  import block_stream_emitter_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 8,
  parameter logic [4:0]  CASE_MASK = 5'b00000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [7:0]         raw_char,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;

  state_e             state_q, state_d;
  word_e              word_q, word_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         raw_q, raw_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [7:0]         out_q, out_d;
  logic               valid_q, valid_d;

  logic [7:0]         rom_char;
  logic               last_char;
  logic               accept;
  logic               flush_dec;
  logic [DEPTH_W-1:0] depth_base;

  block_word_rom #(
    .CASE_MASK(CASE_MASK)
  ) u_rom (
    .word_i     (word_q),
    .idx_i      (idx_q),
    .raw_char_i (raw_q),
    .char_o     (rom_char)
  );

  assign last_char = (idx_q == (word_len(word_q) - 3'd1));
  assign accept    = cmd_valid && cmd_ready;
  // A flush level closes at the edge that loads its trailing space.
  assign flush_dec  = (state_q == ST_FLUSH) && last_char;
  assign depth_base = flush_dec ? (depth_q - DEPTH_ONE) : depth_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q  <= WORD_RAW;
      idx_q   <= 3'd0;
      raw_q   <= 8'h00;
      depth_q <= DEPTH_ZERO;
      err_q   <= 1'b0;
      out_q   <= CH_SPACE;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      raw_q   <= raw_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    raw_d   = raw_q;
    depth_d = depth_base;
    err_d   = err_q;
    out_d   = CH_SPACE;
    valid_d = 1'b0;

    if (state_q != ST_IDLE) begin
      out_d   = rom_char;
      valid_d = 1'b1;
      if (!last_char) begin
        idx_d = idx_q + 3'd1;
      end else if (cmd_ready) begin
        state_d = ST_IDLE;
      end else begin
        // Another END word of the flush follows.
        idx_d = 3'd0;
      end
    end

    if (accept) begin
      case (cmd)
        OP_BEGIN: begin
          state_d = ST_EMIT;
          word_d  = WORD_BEGIN;
          idx_d   = 3'd0;
          if (depth_base == DEPTH_MAX) begin
            err_d = 1'b1;
          end else begin
            depth_d = depth_base + DEPTH_ONE;
          end
        end
        OP_END: begin
          state_d = ST_EMIT;
          word_d  = WORD_END;
          idx_d   = 3'd0;
          if (depth_base == DEPTH_ZERO) begin
            err_d = 1'b1;
          end else begin
            depth_d = depth_base - DEPTH_ONE;
          end
        end
        OP_RAW: begin
          state_d = ST_EMIT;
          word_d  = WORD_RAW;
          idx_d   = 3'd0;
          raw_d   = raw_char;
        end
        default: begin
          // FLUSH with nothing open is a no-op.
          if (depth_base != DEPTH_ZERO) begin
            state_d = ST_FLUSH;
            word_d  = WORD_END;
            idx_d   = 3'd0;
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_EMIT:  cmd_ready = last_char;
      ST_FLUSH: cmd_ready = last_char && (depth_q == DEPTH_ONE);
      default:  cmd_ready = 1'b0;
    endcase
  end

  assign balanced  = (depth_q == DEPTH_ZERO) && !err_q;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign depth     = depth_q;
  assign err       = err_q;

endmodule

// File: tb/tb_block_stream_emitter.sv
module tb_block_stream_emitter;

  localparam int         DW   = 3;
  localparam int         MAXD = 7;
  localparam logic [4:0] MASK = 5'b01001;

  localparam logic [1:0] C_BEGIN = 2'b00;
  localparam logic [1:0] C_END   = 2'b01;
  localparam logic [1:0] C_RAW   = 2'b10;
  localparam logic [1:0] C_FLUSH = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [7:0]    raw_char = 8'h00;
  logic          cmd_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic [DW-1:0] depth;
  logic          balanced;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of characters still to be emitted, one per
  // cycle. The emitter can take a command whenever at most one character
  // remains. Spaces that close a flushed level carry a depth decrement.
  typedef struct {
    logic [7:0] ch;
    bit         dec;
  } ent_t;

  ent_t       q[$];
  int         m_depth = 0;
  bit         m_err = 1'b0;
  logic [7:0] m_out = 8'h20;
  bit         m_valid = 1'b0;
  bit         m_acc = 1'b0;

  always #5 clk = ~clk;

  block_stream_emitter #(
    .DEPTH_W   (DW),
    .CASE_MASK (MASK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .raw_char  (raw_char),
    .cmd_ready (cmd_ready),
    .out       (out),
    .out_valid (out_valid),
    .depth     (depth),
    .balanced  (balanced),
    .err       (err)
  );

  function automatic logic [7:0] word_char(input bit is_begin, input int i);
    string      w;
    logic [7:0] ch;
    logic [4:0] mk;
    mk = MASK;
    if (is_begin) w = "begin ";
    else w = "end ";
    ch = w[i];
    if (i < 5) begin
      if (ch != 8'h20 && mk[i]) ch = ch - 8'd32;
    end
    return ch;
  endfunction

  task automatic push_word(input bit is_begin, input bit from_flush);
    int n;
    n = is_begin ? 6 : 4;
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.ch  = word_char(is_begin, i);
      e.dec = from_flush && (i == n - 1);
      q.push_back(e);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, settle 1 time unit.
  task automatic step(input bit rst_n, input bit v, input logic [1:0] c, input logic [7:0] r);
    bit   ready_m;
    ent_t e;
    @(negedge clk);
    reset     = rst_n;
    cmd_valid = v;
    cmd       = c;
    raw_char  = r;
    ready_m   = (q.size() <= 1);
    m_acc     = rst_n && v && ready_m;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_depth = 0;
      m_err   = 1'b0;
      m_out   = 8'h20;
      m_valid = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e       = q.pop_front();
        m_out   = e.ch;
        m_valid = 1'b1;
        if (e.dec) m_depth--;
      end else begin
        m_out   = 8'h20;
        m_valid = 1'b0;
      end
      if (m_acc) begin
        case (c)
          C_BEGIN: begin
            push_word(1'b1, 1'b0);
            if (m_depth == MAXD) m_err = 1'b1;
            else m_depth++;
          end
          C_END: begin
            push_word(1'b0, 1'b0);
            if (m_depth == 0) m_err = 1'b1;
            else m_depth--;
          end
          C_RAW: begin
            e.ch  = r;
            e.dec = 1'b0;
            q.push_back(e);
          end
          default: begin
            for (int k = 0; k < m_depth; k++) push_word(1'b0, 1'b1);
          end
        endcase
      end
    end
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] r);
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b1, c, r);
      if (m_acc) break;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      step(1'b1, 1'b0, 2'b00, 8'h00);
    end
    step(1'b1, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b0, 1'b1, C_BEGIN, 8'h00);
    n_cmp++; if (out !== 8'h20) begin n_bad++; $display("FAIL reset_out: got %h want 20", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (balanced !== 1'b1) begin n_bad++; $display("FAIL reset_balanced: got %b want 1", balanced); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_begin_word();
    string      exp_s;
    logic [7:0] e;
    exp_s = "BegIn ";
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b1, C_BEGIN, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL begin_latency: got valid %b want 0", out_valid); end
    n_cmp++; if (depth !== 3'd1) begin n_bad++; $display("FAIL begin_depth: got %0d want 1", depth); end
    n_cmp++; if (balanced !== 1'b0) begin n_bad++; $display("FAIL begin_balanced: got %b want 0", balanced); end
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 2'b00, 8'h00);
      e = exp_s[k];
      n_cmp++; if (out !== e || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL begin_char%0d: got %h/%b want %h/1", k, out, out_valid, e);
      end
    end
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out_valid !== 1'b0 || out !== 8'h20) begin
      n_bad++; $display("FAIL begin_after: got %h/%b want 20/0", out, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    string      exp_s;
    logic [7:0] got[$];
    logic [7:0] e;
    bit         end_done;
    int         first, last;
    exp_s = "BegIn End ";
    end_done = 1'b0;
    first = -1;
    last = -1;
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b1, C_BEGIN, 8'h00);
    for (int k = 0; k < 14; k++) begin
      step(1'b1, !end_done, C_END, 8'h00);
      if (m_acc) end_done = 1'b1;
      n_cmp++; if (out !== m_out || out_valid !== m_valid) begin
        n_bad++; $display("FAIL b2b_cycle%0d: got %h/%b want %h/%b", k, out, out_valid, m_out, m_valid);
      end
      if (out_valid) begin
        got.push_back(out);
        if (first < 0) first = k;
        last = k;
      end
    end
    n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", got.size()); end
    n_cmp++; if (last - first + 1 != 10) begin n_bad++; $display("FAIL b2b_gap: got span %0d want 10", last - first + 1); end
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      e = exp_s[k];
      n_cmp++; if (got[k] !== e) begin n_bad++; $display("FAIL b2b_char%0d: got %h want %h", k, got[k], e); end
    end
    n_cmp++; if (depth !== 3'd0 || balanced !== 1'b1) begin
      n_bad++; $display("FAIL b2b_final: got depth %0d bal %b want 0/1", depth, balanced);
    end
  endtask

  task automatic test_flush();
    int seen_depth[$];
    int nchars;
    nchars = 0;
    step(1'b0, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 3; k++) issue(C_BEGIN, 8'h00);
    drain();
    n_cmp++; if (depth !== 3'd3) begin n_bad++; $display("FAIL flush_pre_depth: got %0d want 3", depth); end
    step(1'b1, 1'b1, C_FLUSH, 8'h00);
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, 2'b00, 8'h00);
      n_cmp++; if (out !== m_out || out_valid !== m_valid || depth !== DW'(m_depth)) begin
        n_bad++; $display("FAIL flush_cycle%0d: got %h/%b/%0d want %h/%b/%0d",
                          k, out, out_valid, depth, m_out, m_valid, m_depth);
      end
      n_cmp++; if (cmd_ready !== (q.size() <= 1)) begin
        n_bad++; $display("FAIL flush_ready%0d: got %b want %b", k, cmd_ready, q.size() <= 1);
      end
      if (out_valid) nchars++;
      if (out_valid && out == 8'h20) seen_depth.push_back(int'(depth));
    end
    n_cmp++; if (nchars != 12) begin n_bad++; $display("FAIL flush_count: got %0d want 12", nchars); end
    n_cmp++; if (seen_depth.size() != 3) begin n_bad++; $display("FAIL flush_spaces: got %0d want 3", seen_depth.size()); end
    for (int j = 0; j < 3 && j < seen_depth.size(); j++) begin
      n_cmp++; if (seen_depth[j] != 2 - j) begin
        n_bad++; $display("FAIL flush_step%0d: got %0d want %0d", j, seen_depth[j], 2 - j);
      end
    end
    n_cmp++; if (balanced !== 1'b1) begin n_bad++; $display("FAIL flush_balanced: got %b want 1", balanced); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 2'b00, 8'h00);
    issue(C_END, 8'h00);
    drain();
    n_cmp++; if (err !== 1'b1 || depth !== 3'd0 || balanced !== 1'b0) begin
      n_bad++; $display("FAIL underflow: got err %b depth %0d bal %b want 1/0/0", err, depth, balanced);
    end
    issue(C_BEGIN, 8'h00);
    issue(C_END, 8'h00);
    drain();
    n_cmp++; if (err !== 1'b1 || depth !== 3'd0 || balanced !== 1'b0) begin
      n_bad++; $display("FAIL underflow_sticky: got err %b depth %0d bal %b want 1/0/0", err, depth, balanced);
    end
  endtask

  task automatic test_raw_and_empty_flush();
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b1, C_RAW, 8'h41);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out !== 8'h41 || out_valid !== 1'b1 || depth !== 3'd0) begin
      n_bad++; $display("FAIL raw: got %h/%b/%0d want 41/1/0", out, out_valid, depth);
    end
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL raw_single: got valid %b want 0", out_valid); end
    step(1'b1, 1'b1, C_FLUSH, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out_valid !== 1'b0 || out !== 8'h20 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_empty: got %h/%b ready %b want 20/0 ready 1", out, out_valid, cmd_ready);
    end
  endtask

  task automatic test_max_depth();
    int nchars;
    nchars = 0;
    step(1'b0, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < MAXD + 1; k++) issue(C_BEGIN, 8'h00);
    drain();
    n_cmp++; if (depth !== DW'(MAXD) || err !== 1'b1) begin
      n_bad++; $display("FAIL max_depth: got depth %0d err %b want %0d/1", depth, err, MAXD);
    end
    issue(C_FLUSH, 8'h00);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 2'b00, 8'h00);
      if (out_valid) nchars++;
    end
    n_cmp++; if (nchars != 4 * MAXD) begin n_bad++; $display("FAIL max_flush_count: got %0d want %0d", nchars, 4 * MAXD); end
    n_cmp++; if (depth !== 3'd0 || err !== 1'b1) begin
      n_bad++; $display("FAIL max_flush_final: got depth %0d err %b want 0/1", depth, err);
    end
  endtask

  task automatic test_reset_midword();
    step(1'b0, 1'b0, 2'b00, 8'h00);
    issue(C_END, 8'h00);
    drain();
    step(1'b1, 1'b1, C_BEGIN, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out !== 8'h67) begin n_bad++; $display("FAIL midword_third: got %h want 67", out); end
    step(1'b0, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out !== 8'h20 || out_valid !== 1'b0 || depth !== 3'd0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL midword_reset: got %h/%b depth %0d err %b ready %b want 20/0 0 0 1",
                        out, out_valid, depth, err, cmd_ready);
    end
    step(1'b1, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midword_abandon: got valid %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit         rst_n;
    bit         v;
    logic [1:0] c;
    logic [7:0] r;
    step(1'b0, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      v     = ($urandom_range(0, 1) == 1);
      c     = 2'($urandom_range(0, 3));
      if (c == C_FLUSH && $urandom_range(0, 2) != 0) c = C_BEGIN;
      r     = 8'($urandom_range(0, 255));
      step(rst_n, v, c, r);
      n_cmp++; if (out !== m_out) begin n_bad++; $display("FAIL rand_out%0d: got %h want %h", k, out, m_out); end
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid%0d: got %b want %b", k, out_valid, m_valid); end
      n_cmp++; if (depth !== DW'(m_depth)) begin n_bad++; $display("FAIL rand_depth%0d: got %0d want %0d", k, depth, m_depth); end
      n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rand_err%0d: got %b want %b", k, err, m_err); end
      n_cmp++; if (balanced !== (m_depth == 0 && !m_err)) begin
        n_bad++; $display("FAIL rand_balanced%0d: got %b want %b", k, balanced, (m_depth == 0 && !m_err));
      end
      n_cmp++; if (cmd_ready !== (q.size() <= 1)) begin
        n_bad++; $display("FAIL rand_ready%0d: got %b want %b", k, cmd_ready, q.size() <= 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_begin_word();
    test_back_to_back();
    test_flush();
    test_underflow();
    test_raw_and_empty_flush();
    test_max_depth();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
